// File: rtl/spike_input_encoder.sv
// Rate-coded spike encoder: scans input pixels against an LFSR sample and pushes the
// indices of spiking inputs into the input-spike FIFO.
module spike_input_encoder #(
  parameter int unsigned M          = 8,
  parameter int unsigned INPUT_RESO = 8,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  start_i,
  input  logic                  next_tick_i,
  input  logic [M-1:0]          last_idx_i,
  output logic                  pix_req_o,
  output logic [M-1:0]          pix_addr_o,
  input  logic [INPUT_RESO-1:0] pix_data_i,
  output logic                  FIFO_w_en_o,
  output logic [M-1:0]          FIFO_w_data_o,
  input  logic                  FIFO_full_i,
  output logic                  spikecore_done_o,
  output logic                  busy_o,
  output logic [M:0]            spike_count_o
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCompare,
    StPush,
    StNext,
    StDone
  } state_e;

  localparam logic [M:0] CntMax = {1'b1, {M{1'b0}}};

  state_e       state_q, state_d;
  logic [M-1:0] idx_q, idx_d;
  logic [M:0]   cnt_q, cnt_d;
  logic [7:0]   lfsr_q, lfsr_d;
  logic         start_q;
  logic         trigger;
  logic [7:0]   lfsr_next;

  // Rising start level or a tick while enabled both launch a scan.
  assign trigger   = start_i && (!start_q || next_tick_i);
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      start_q <= start_i;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StCompare;
      StCompare: begin
        lfsr_d  = lfsr_next;
        state_d = (pix_data_i >= lfsr_q) ? StPush : StNext;
      end
      StPush: begin
        // Hold here while the FIFO is full so no spike is dropped.
        if (!FIFO_full_i) begin
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
          state_d = StNext;
        end
      end
      StNext: begin
        if (idx_q == last_idx_i) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StFetch;
        end
      end
      StDone: begin
        if (!start_i) begin
          state_d = StIdle;
        end else if (next_tick_i) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pix_req_o        = 1'b0;
    pix_addr_o       = '0;
    FIFO_w_en_o      = 1'b0;
    FIFO_w_data_o    = '0;
    spikecore_done_o = 1'b0;
    busy_o           = 1'b0;
    spike_count_o    = cnt_q;
    unique case (state_q)
      StFetch: begin
        pix_req_o  = 1'b1;
        pix_addr_o = idx_q;
        busy_o     = 1'b1;
      end
      StCompare: busy_o = 1'b1;
      StPush: begin
        busy_o = 1'b1;
        if (!FIFO_full_i) begin
          FIFO_w_en_o   = 1'b1;
          FIFO_w_data_o = idx_q;
        end
      end
      StNext: busy_o = 1'b1;
      StDone: spikecore_done_o = 1'b1;
      default: ;
    endcase
  end

endmodule
